candidate_topk_sorter: RTL and testbench

- Upstream feeder of the control unit's candidate stage.
- Consumes a stream of scored coarse-search angles {score, theta, phi}.
- Keeps the K best entries in descending score order, packed into candidate_angle_buffer.
- Asserts sorted_rdy once the final beat has been inserted; the downstream control unit then starts fine search over the buffer.

---
 rtl/candidate_topk_sorter.sv | 156 +++++++++++++++
 tb/tb_candidate_topk_sorter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/candidate_topk_sorter.sv
// candidate_topk_sorter
// Collects a stream of scored coarse-search angles and keeps the K best
// entries in descending score order for the downstream fine-search stage.
// Incoming beats are registered once (stage 1) and inserted into the sorted
// buffer on the following edge (stage 2), sustaining one beat per cycle.

module candidate_topk_sorter #(
    parameter int K       = 10,
    parameter int SCORE_W = 16,
    parameter int ANG_W   = 12,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SCORE_W-1:0]       in_score,
    input  logic [ANG_W-1:0]         in_theta,
    input  logic [ANG_W-1:0]         in_phi,
    input  logic                     in_last,
    output logic [K*2*ANG_W-1:0]     candidate_angle_buffer,
    output logic [K*SCORE_W-1:0]     candidate_score_buffer,
    output logic [CNT_W-1:0]         cand_count,
    output logic                     sorted_rdy,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] CNT_K = CNT_W'(K);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 r_state;

    logic                   r_pipeValid;
    logic [SCORE_W-1:0]     r_pipeScore;
    logic [2*ANG_W-1:0]     r_pipeAngle;

    logic [SCORE_W-1:0]     r_score [K];
    logic [2*ANG_W-1:0]     r_angle [K];
    logic [K-1:0]           r_valid;
    logic [CNT_W-1:0]       r_count;

    logic                   w_accept;
    logic                   w_start;
    logic                   w_insert;
    logic [CNT_W-1:0]       w_pos;
    logic [SCORE_W-1:0]     w_nextScore [K];
    logic [2*ANG_W-1:0]     w_nextAngle [K];
    logic [K-1:0]           w_nextValid;

    assign w_accept = in_valid && (r_state == S_COLLECT);
    assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_insert = r_pipeValid && (w_pos < CNT_K);

    assign in_ready   = (r_state == S_COLLECT);
    assign busy       = (r_state == S_COLLECT) || (r_state == S_FLUSH);
    assign sorted_rdy = (r_state == S_DONE);
    assign cand_count = r_count;

    // Run control: a start only opens a run from IDLE or DONE, and the run closes one edge after the last beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) r_state <= S_COLLECT;
                S_COLLECT: if (w_accept && in_last) r_state <= S_FLUSH;
                S_FLUSH:   r_state <= S_DONE;
                S_DONE:    if (start) r_state <= S_COLLECT;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: capture each accepted beat so the ranking logic sees a registered operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipeValid <= 1'b0;
            r_pipeScore <= '0;
            r_pipeAngle <= '0;
        end else begin
            r_pipeValid <= w_accept;
            if (w_accept) begin
                r_pipeScore <= in_score;
                r_pipeAngle <= {in_theta, in_phi};
            end
        end
    end

    // Rank of the pending beat: valid entries scoring at least as high stay ahead, so ties keep arrival order.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < K; i++) begin
            if (r_valid[i] && (r_score[i] >= r_pipeScore)) begin
                w_pos = w_pos + CNT_W'(1);
            end
        end
    end

    // Candidate buffer after insertion: slots above the rank hold, the rank slot takes the new beat, slots below shift down by one.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_nextScore[i] = r_score[i];
            w_nextAngle[i] = r_angle[i];
            w_nextValid[i] = r_valid[i];
        end
        for (int i = 1; i < K; i++) begin
            if (CNT_W'(i) > w_pos) begin
                w_nextScore[i] = r_score[i-1];
                w_nextAngle[i] = r_angle[i-1];
                w_nextValid[i] = r_valid[i-1];
            end
        end
        for (int i = 0; i < K; i++) begin
            if (CNT_W'(i) == w_pos) begin
                w_nextScore[i] = r_pipeScore;
                w_nextAngle[i] = r_pipeAngle;
                w_nextValid[i] = 1'b1;
            end
        end
    end

    // Stage 2: commit the insertion, or wipe the buffer when a new run opens.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            for (int i = 0; i < K; i++) begin
                r_score[i] <= '0;
                r_angle[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (w_insert) begin
            for (int i = 0; i < K; i++) begin
                r_score[i] <= w_nextScore[i];
                r_angle[i] <= w_nextAngle[i];
            end
            r_valid <= w_nextValid;
            if (r_count < CNT_K) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Flatten the entry registers onto the packed output buses, entry 0 in the low bits.
    for (genvar g = 0; g < K; g++) begin : g_pack
        assign candidate_angle_buffer[g*2*ANG_W +: 2*ANG_W] = r_angle[g];
        assign candidate_score_buffer[g*SCORE_W +: SCORE_W] = r_score[g];
    end

endmodule

// File: tb/tb_candidate_topk_sorter.sv
// tb_candidate_topk_sorter
// Scoreboard bench: a behavioural top-K model is updated for every beat
// driven, the expected final buffer is queued at the last beat, and it is
// popped and compared once the design reports sorted_rdy.

module tb_candidate_topk_sorter;

    localparam int K       = 10;
    localparam int SCORE_W = 16;
    localparam int ANG_W   = 12;
    localparam int CNT_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [SCORE_W-1:0]     in_score;
    logic [ANG_W-1:0]       in_theta;
    logic [ANG_W-1:0]       in_phi;
    logic                   in_last;
    logic [K*2*ANG_W-1:0]   candidate_angle_buffer;
    logic [K*SCORE_W-1:0]   candidate_score_buffer;
    logic [CNT_W-1:0]       cand_count;
    logic                   sorted_rdy;
    logic                   busy;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [K*2*ANG_W-1:0] angles;
        logic [K*SCORE_W-1:0] scores;
        int                   count;
    } expect_t;

    expect_t expQ[$];

    logic [SCORE_W-1:0] mScore [K];
    logic [2*ANG_W-1:0] mAngle [K];
    int                 mCount;

    candidate_topk_sorter #(
        .K(K), .SCORE_W(SCORE_W), .ANG_W(ANG_W), .CNT_W(CNT_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_score               (in_score),
        .in_theta               (in_theta),
        .in_phi                 (in_phi),
        .in_last                (in_last),
        .candidate_angle_buffer (candidate_angle_buffer),
        .candidate_score_buffer (candidate_score_buffer),
        .cand_count             (cand_count),
        .sorted_rdy             (sorted_rdy),
        .busy                   (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task model_clear;
        for (int i = 0; i < K; i++) begin
            mScore[i] = '0;
            mAngle[i] = '0;
        end
        mCount = 0;
    endtask

    task model_insert(input logic [SCORE_W-1:0] s, input logic [ANG_W-1:0] t, input logic [ANG_W-1:0] p);
        int pos;
        pos = mCount;
        for (int i = 0; i < mCount; i++) begin
            if (s > mScore[i]) begin
                pos = i;
                break;
            end
        end
        if (pos < K) begin
            for (int j = K - 1; j > pos; j--) begin
                mScore[j] = mScore[j-1];
                mAngle[j] = mAngle[j-1];
            end
            mScore[pos] = s;
            mAngle[pos] = {t, p};
            if (mCount < K) mCount++;
        end
    endtask

    task push_expect;
        expect_t e;
        for (int i = 0; i < K; i++) begin
            e.angles[i*2*ANG_W +: 2*ANG_W] = mAngle[i];
            e.scores[i*SCORE_W +: SCORE_W] = mScore[i];
        end
        e.count = mCount;
        expQ.push_back(e);
    endtask

    task pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task send_beat(input logic [SCORE_W-1:0] s, input logic [ANG_W-1:0] t,
                   input logic [ANG_W-1:0] p, input logic last);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_score = s;
        in_theta = t;
        in_phi   = p;
        in_last  = last;
        while (!in_ready && waitCycles < 50) begin
            tick;
            waitCycles++;
        end
        testsRun++;
        if (!in_ready) begin
            testsFailed++;
            $display("[TB] FAIL beat_accept in_ready got %0b want 1", in_ready);
        end else begin
            model_insert(s, t, p);
            if (last) push_expect;
        end
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task drain_scoreboard(input string name);
        int waitCycles;
        expect_t e;
        waitCycles = 0;
        while (!sorted_rdy && waitCycles < 100) begin
            tick;
            waitCycles++;
        end
        testsRun++;
        if (!sorted_rdy) begin
            testsFailed++;
            $display("[TB] FAIL %s sorted_rdy timeout got 0 want 1", name);
            if (expQ.size() != 0) void'(expQ.pop_front());
            return;
        end
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s scoreboard empty got 0 entries want 1", name);
            return;
        end
        e = expQ.pop_front();
        testsRun++;
        if (candidate_angle_buffer !== e.angles) begin
            testsFailed++;
            $display("[TB] FAIL %s angles got %h want %h", name, candidate_angle_buffer, e.angles);
        end
        testsRun++;
        if (candidate_score_buffer !== e.scores) begin
            testsFailed++;
            $display("[TB] FAIL %s scores got %h want %h", name, candidate_score_buffer, e.scores);
        end
        testsRun++;
        if (int'(cand_count) != e.count) begin
            testsFailed++;
            $display("[TB] FAIL %s cand_count got %0d want %0d", name, cand_count, e.count);
        end
    endtask

    task test_reset;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_score = '0;
        in_theta = '0;
        in_phi = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        tick;
        tick;
        testsRun++;
        if (sorted_rdy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sorted_rdy got %0b want 0", sorted_rdy); end
        testsRun++;
        if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        testsRun++;
        if (cand_count !== '0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", cand_count); end
        testsRun++;
        if (candidate_angle_buffer !== '0) begin testsFailed++; $display("[TB] FAIL reset_angles got %h want 0", candidate_angle_buffer); end
        testsRun++;
        if (candidate_score_buffer !== '0) begin testsFailed++; $display("[TB] FAIL reset_scores got %h want 0", candidate_score_buffer); end
    endtask

    task check_overflow_result(input string name);
        testsRun++;
        if (candidate_angle_buffer[0 +: 2*ANG_W] !== {12'd11, 12'd22}) begin
            testsFailed++; $display("[TB] FAIL %s entry0 got %h want %h", name, candidate_angle_buffer[0 +: 2*ANG_W], {12'd11, 12'd22});
        end
        testsRun++;
        if (candidate_score_buffer[0 +: SCORE_W] !== 16'd1200) begin
            testsFailed++; $display("[TB] FAIL %s score0 got %0d want 1200", name, candidate_score_buffer[0 +: SCORE_W]);
        end
        testsRun++;
        if (candidate_angle_buffer[9*2*ANG_W +: 2*ANG_W] !== {12'd2, 12'd4}) begin
            testsFailed++; $display("[TB] FAIL %s entry9 got %h want %h", name, candidate_angle_buffer[9*2*ANG_W +: 2*ANG_W], {12'd2, 12'd4});
        end
        testsRun++;
        if (candidate_score_buffer[9*SCORE_W +: SCORE_W] !== 16'd300) begin
            testsFailed++; $display("[TB] FAIL %s score9 got %0d want 300", name, candidate_score_buffer[9*SCORE_W +: SCORE_W]);
        end
        testsRun++;
        if (cand_count !== 4'd10) begin
            testsFailed++; $display("[TB] FAIL %s cand_count got %0d want 10", name, cand_count);
        end
    endtask

    task test_overflow;
        model_clear;
        pulse_start;
        testsRun++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL overflow_collect in_ready/busy got %0b/%0b want 1/1", in_ready, busy);
        end
        for (int i = 0; i < 11; i++) begin
            send_beat(SCORE_W'(100 * (i + 1)), ANG_W'(i), ANG_W'(2 * i), 1'b0);
        end
        send_beat(16'd1200, 12'd11, 12'd22, 1'b1);
        testsRun++;
        if (sorted_rdy !== 1'b0 || busy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL overflow_flush sorted_rdy/busy got %0b/%0b want 0/1", sorted_rdy, busy);
        end
        tick;
        testsRun++;
        if (sorted_rdy !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL overflow_latency rdy/ready/busy got %0b/%0b/%0b want 1/0/0", sorted_rdy, in_ready, busy);
        end
        drain_scoreboard("overflow");
        check_overflow_result("overflow");
        tick;
        tick;
        tick;
        testsRun++;
        if (sorted_rdy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL overflow_hold sorted_rdy got %0b want 1", sorted_rdy);
        end
    endtask

    task test_underfill;
        model_clear;
        pulse_start;
        send_beat(16'd5, 12'd1, 12'd101, 1'b0);
        send_beat(16'd50, 12'd2, 12'd102, 1'b0);
        send_beat(16'd20, 12'd3, 12'd103, 1'b1);
        drain_scoreboard("underfill");
        testsRun++;
        if (candidate_angle_buffer[0*2*ANG_W + ANG_W +: ANG_W] !== 12'd2 ||
            candidate_angle_buffer[1*2*ANG_W + ANG_W +: ANG_W] !== 12'd3 ||
            candidate_angle_buffer[2*2*ANG_W + ANG_W +: ANG_W] !== 12'd1) begin
            testsFailed++; $display("[TB] FAIL underfill_order got %h want theta 2,3,1", candidate_angle_buffer[3*2*ANG_W-1:0]);
        end
        testsRun++;
        if (candidate_angle_buffer[K*2*ANG_W-1:3*2*ANG_W] !== '0 || candidate_score_buffer[K*SCORE_W-1:3*SCORE_W] !== '0) begin
            testsFailed++; $display("[TB] FAIL underfill_empty got %h want 0", candidate_angle_buffer[K*2*ANG_W-1:3*2*ANG_W]);
        end
        testsRun++;
        if (cand_count !== 4'd3) begin
            testsFailed++; $display("[TB] FAIL underfill_count got %0d want 3", cand_count);
        end
    endtask

    task test_ties;
        model_clear;
        pulse_start;
        send_beat(16'd7, 12'd10, 12'd1, 1'b0);
        send_beat(16'd7, 12'd11, 12'd2, 1'b0);
        send_beat(16'd7, 12'd12, 12'd3, 1'b1);
        drain_scoreboard("ties");
        testsRun++;
        if (candidate_angle_buffer[0*2*ANG_W + ANG_W +: ANG_W] !== 12'd10 ||
            candidate_angle_buffer[1*2*ANG_W + ANG_W +: ANG_W] !== 12'd11 ||
            candidate_angle_buffer[2*2*ANG_W + ANG_W +: ANG_W] !== 12'd12) begin
            testsFailed++; $display("[TB] FAIL ties_order got %h want theta 10,11,12", candidate_angle_buffer[3*2*ANG_W-1:0]);
        end
        model_clear;
        pulse_start;
        send_beat(16'd0, 12'd5, 12'd6, 1'b1);
        drain_scoreboard("zero_score");
        testsRun++;
        if (candidate_angle_buffer[0 +: 2*ANG_W] !== {12'd5, 12'd6} || cand_count !== 4'd1) begin
            testsFailed++; $display("[TB] FAIL zero_score_entry0 got %h/%0d want %h/1", candidate_angle_buffer[0 +: 2*ANG_W], cand_count, {12'd5, 12'd6});
        end
    endtask

    task test_gaps_ignored_start;
        int gap;
        model_clear;
        pulse_start;
        for (int i = 0; i < 12; i++) begin
            send_beat(SCORE_W'(100 * (i + 1)), ANG_W'(i), ANG_W'(2 * i), (i == 11) ? 1'b1 : 1'b0);
            if (i < 11) begin
                gap = int'($urandom_range(1, 3));
                if (i == 5) begin
                    pulse_start;
                    testsRun++;
                    if (busy !== 1'b1 || in_ready !== 1'b1 || sorted_rdy !== 1'b0 || cand_count !== 4'd6) begin
                        testsFailed++; $display("[TB] FAIL ignored_start busy/ready/rdy/count got %0b/%0b/%0b/%0d want 1/1/0/6", busy, in_ready, sorted_rdy, cand_count);
                    end
                    gap = gap - 1;
                end
                for (int g = 0; g < gap; g++) tick;
            end
        end
        drain_scoreboard("gaps");
        check_overflow_result("gaps");
    endtask

    task test_reset_midrun;
        model_clear;
        pulse_start;
        for (int i = 0; i < 5; i++) begin
            send_beat(SCORE_W'(30 + i), ANG_W'(i + 1), ANG_W'(i + 2), 1'b0);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        testsRun++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || sorted_rdy !== 1'b0 || cand_count !== '0) begin
            testsFailed++; $display("[TB] FAIL midrun_reset busy/ready/rdy/count got %0b/%0b/%0b/%0d want 0/0/0/0", busy, in_ready, sorted_rdy, cand_count);
        end
        testsRun++;
        if (candidate_angle_buffer !== '0 || candidate_score_buffer !== '0) begin
            testsFailed++; $display("[TB] FAIL midrun_reset_buffers got %h want 0", candidate_score_buffer);
        end
        model_clear;
    endtask

    task test_restart_from_done;
        model_clear;
        pulse_start;
        for (int i = 0; i < 4; i++) begin
            send_beat(SCORE_W'($urandom_range(1, 900)), ANG_W'(i + 40), ANG_W'(i + 80), (i == 3) ? 1'b1 : 1'b0);
        end
        drain_scoreboard("pre_restart");
        pulse_start;
        testsRun++;
        if (sorted_rdy !== 1'b0 || cand_count !== '0 || busy !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL restart rdy/count/busy got %0b/%0d/%0b want 0/0/1", sorted_rdy, cand_count, busy);
        end
        testsRun++;
        if (candidate_score_buffer !== '0) begin
            testsFailed++; $display("[TB] FAIL restart_cleared got %h want 0", candidate_score_buffer);
        end
        model_clear;
        for (int i = 0; i < 15; i++) begin
            send_beat(SCORE_W'($urandom_range(0, 20)), ANG_W'($urandom_range(0, 4095)),
                      ANG_W'($urandom_range(0, 4095)), (i == 14) ? 1'b1 : 1'b0);
        end
        drain_scoreboard("restart_run");
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset;
        test_overflow;
        test_underfill;
        test_ties;
        test_gaps_ignored_start;
        test_reset_midrun;
        test_restart_from_done;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
